// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if
//   Bundles every signal of the I-cache refill controller except clock and reset:
//   the I-cache request port, the data-array fill port and the AXI4 AR/R read
//   channels.
//
//   Modports:
//     master : the refill controller (drives req_ready, fill_*, done, err,
//              AR channel and rready)
//     slave  : the environment (I-cache and AXI slave side)
//
//   Handshake rule for req, AR and R: a transfer happens on a rising clock edge
//   where valid and ready are both 1. A source that has raised valid holds it and
//   its payload steady until that edge.
interface icache_refill_ctrl_if #(
    parameter int LINE_WORDS = 4
);
    localparam int IW = $clog2(LINE_WORDS);

    // I-cache request
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    // Data-array fill and completion
    logic          fill_valid;
    logic [IW-1:0] fill_idx;
    logic [31:0]   fill_data;
    logic          done;
    logic          err;
    // AXI AR channel
    logic          arvalid;
    logic          arready;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic [3:0]    arid;
    // AXI R channel
    logic          rvalid;
    logic          rready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic [3:0]    rid;

    modport master (
        input  req_valid, req_addr, arready, rvalid, rdata, rresp, rlast, rid,
        output req_ready, fill_valid, fill_idx, fill_data, done, err,
               arvalid, araddr, arlen, arsize, arburst, arid, rready
    );

    modport slave (
        output req_valid, req_addr, arready, rvalid, rdata, rresp, rlast, rid,
        input  req_ready, fill_valid, fill_idx, fill_data, done, err,
               arvalid, araddr, arlen, arsize, arburst, arid, rready
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//   Fetches one I-cache line over an AXI4 read channel, either as a single INCR
//   burst (BURST_EN=1) or as LINE_WORDS single-beat reads (BURST_EN=0). Each
//   returned word is written into the data array; done pulses with the last
//   fill and err reports whether any beat of the line looked wrong.
//
//   Ports:
//     clock     : system clock
//     reset     : asynchronous, active-high reset
//     bus       : icache_refill_ctrl_if.master (request, fill, AXI AR/R)
//     dbg_state : current FSM state (0 IDLE, 1 AR, 2 R, 3 DONE)
module icache_refill_ctrl #(
    parameter int         LINE_WORDS = 4,
    parameter bit         BURST_EN   = 1'b1,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                        clock,
    input  logic                        reset,
    icache_refill_ctrl_if.master        bus,
    output logic [1:0]                  dbg_state
);
    localparam int            IW        = $clog2(LINE_WORDS);
    localparam int            OFS       = IW + 2;
    localparam logic [IW-1:0] LAST_BEAT = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] beat_q, beat_d;
    logic [31:0]   base_q, base_d;
    logic          err_sticky_q, err_sticky_d;
    logic          req_ready_q, req_ready_d;
    logic          arvalid_q, arvalid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic [1:0]    arburst_q, arburst_d;
    logic          rready_q, rready_d;
    logic          fill_valid_q, fill_valid_d;
    logic [IW-1:0] fill_idx_q, fill_idx_d;
    logic [31:0]   fill_data_q, fill_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [31:0]   req_base;
    logic [IW-1:0] beat_nxt;
    logic          exp_last;
    logic          beat_err;
    logic          unused_addr_bits;

    // Offset bits inside the line are dropped: the whole line is always fetched.
    assign req_base         = {bus.req_addr[31:OFS], {OFS{1'b0}}};
    assign unused_addr_bits = ^bus.req_addr[OFS-1:0];
    assign beat_nxt         = beat_q + IW'(1);
    // Single-beat reads each end in rlast; a burst ends only on its final beat.
    assign exp_last = BURST_EN ? (beat_q == LAST_BEAT) : 1'b1;
    assign beat_err = (bus.rresp != 2'b00) || (bus.rid != AXI_ID) || (bus.rlast != exp_last);

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        base_d       = base_q;
        err_sticky_d = err_sticky_q;
        req_ready_d  = req_ready_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arburst_d    = arburst_q;
        rready_d     = rready_q;
        fill_valid_d = 1'b0;
        fill_idx_d   = fill_idx_q;
        fill_data_d  = fill_data_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    base_d       = req_base;
                    beat_d       = '0;
                    err_sticky_d = 1'b0;
                    req_ready_d  = 1'b0;
                    arvalid_d    = 1'b1;
                    araddr_d     = req_base;
                    arlen_d      = BURST_EN ? 8'(LINE_WORDS - 1) : 8'd0;
                    arburst_d    = 2'b01;
                    state_d      = S_AR;
                end
            end
            S_AR: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (bus.rvalid) begin
                    fill_valid_d = 1'b1;
                    fill_idx_d   = beat_q;
                    fill_data_d  = bus.rdata;
                    err_sticky_d = err_sticky_q | beat_err;
                    beat_d       = beat_nxt;
                    // Beats are counted; rlast is only checked, never trusted.
                    if (beat_q == LAST_BEAT) begin
                        rready_d = 1'b0;
                        done_d   = 1'b1;
                        err_d    = err_sticky_q | beat_err;
                        state_d  = S_DONE;
                    end else if (!BURST_EN) begin
                        rready_d  = 1'b0;
                        arvalid_d = 1'b1;
                        araddr_d  = base_q + (32'(beat_nxt) << 2);
                        state_d   = S_AR;
                    end
                end
            end
            S_DONE: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            err_sticky_q <= 1'b0;
            req_ready_q  <= 1'b1;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arburst_q    <= '0;
            rready_q     <= 1'b0;
            fill_valid_q <= 1'b0;
            fill_idx_q   <= '0;
            fill_data_q  <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            err_sticky_q <= err_sticky_d;
            req_ready_q  <= req_ready_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arburst_q    <= arburst_d;
            rready_q     <= rready_d;
            fill_valid_q <= fill_valid_d;
            fill_idx_q   <= fill_idx_d;
            fill_data_q  <= fill_data_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_idx   = fill_idx_q;
    assign bus.fill_data  = fill_data_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.arvalid    = arvalid_q;
    assign bus.araddr     = araddr_q;
    assign bus.arlen      = arlen_q;
    assign bus.arsize     = 3'b010;
    assign bus.arburst    = arburst_q;
    assign bus.arid       = AXI_ID;
    assign bus.rready     = rready_q;
    assign dbg_state      = state_q;
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Sequences I-cache line refills over the AXI4 master read channel. Takes one miss request from the I-cache and fetches one full line, either as a single INCR burst or as a series of single-beat reads for slaves without burst support. Writes each returned word into the cache data array and signals completion and error status. Sits between the I-cache and master port 0 of the bus arbiter.

Parameters:
LINE_WORDS, 4, words per cache line; power of two, 2..16.
BURST_EN, 1, 1 = one INCR burst per line; 0 = LINE_WORDS single-beat reads.
AXI_ID, 0, constant value driven on arid.
IW, log2(LINE_WORDS), width of fill_idx (derived, not overridden).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  refill request from the I-cache
req_ready  out  1  controller idle and accepting a request
req_addr  in  32  miss address; low log2(LINE_WORDS)+2 bits are ignored
fill_valid  out  1  write strobe for one word into the data array
fill_idx  out  IW  word index within the line
fill_data  out  32  word to write
done  out  1  one-cycle pulse when the line is complete
err  out  1  error status of the line; valid only while done=1
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  32  AXI AR address
arlen  out  8  AXI AR burst length
arsize  out  3  always 3'b010
arburst  out  2  AXI AR burst type
arid  out  4  always AXI_ID
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last beat
rid  in  4  AXI R id

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs are 0 except req_ready=1. The beat counter, sticky error and base register clear. An in-flight transaction is abandoned; it is not drained.
- States: IDLE, AR, R, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready:
  - base <= req_addr with low log2(LINE_WORDS)+2 bits cleared.
  - beat counter <= 0, err_sticky <= 0.
  - Next state is AR.
  - req_ready=0 in every state except IDLE.
- AR: arvalid=1.
  - araddr = base + 4*beat.
  - BURST_EN=1: arlen=LINE_WORDS-1, arburst=2'b01.
  - BURST_EN=0: arlen=0, arburst=2'b01.
  - All AR fields stay stable until arready. On arvalid&&arready, next state is R; arvalid drops the following cycle.
- R: rready=1. Each rvalid&&rready is one beat. On each beat:
  - The registered outputs take effect the next cycle: fill_valid=1, fill_idx=beat, fill_data=rdata.
  - err_sticky |= (rresp!=2'b00) | (rid!=AXI_ID) | (rlast != expected_last).
  - expected_last = 1 on the final beat of a burst (BURST_EN=1), and 1 on every beat when BURST_EN=0.
  - beat increments, wrapping within IW bits.
- Beat completion: the controller counts beats and never waits on rlast.
  - Final beat of the line (beat==LINE_WORDS-1): next state is DONE.
  - Otherwise, BURST_EN=0: next state is AR (next word address).
  - Otherwise, BURST_EN=1: stay in R.
- DONE: lasts exactly one cycle. done=1 and err=err_sticky. This cycle coincides with fill_valid for the last word. Next state is IDLE, so req_ready=1 the following cycle.
- Errors never abort a line: all LINE_WORDS beats are consumed and written.
- The controller never issues a second AR before the current R data completes; at most one transaction is outstanding.
- rvalid seen outside state R is ignored: rready=0 and no fill occurs.
- Minimum latency with slave arready and rvalid immediate: request accepted at cycle 0, done at cycle LINE_WORDS+2 for burst mode, 2*LINE_WORDS+1 for single-beat mode.

Test Plan:
- Burst OK: BURST_EN=1, req_addr=0x3000_0014 -> araddr=0x3000_0010, arlen=3, arburst=01. 4 beats 0xA0..0xA3 with rlast on beat 3 -> fill_idx 0..3 carry A0..A3; done=1 with err=0 in the same cycle as fill_idx=3.
- Single-beat mode: BURST_EN=0, req_addr=0x8000_003C -> four ARs at 0x8000_0030/34/38/3C, each arlen=0 with rlast=1 -> 4 fills, done with err=0.
- Error sticky: rresp=2'b10 on beat 1 only -> all 4 fills still occur; err=1 at done. The next clean request -> err=0.
- rlast protocol: rlast asserted on beat 2 of 4 -> line still completes after 4 beats with err=1. rid=5 with AXI_ID=0 -> err=1.
- Backpressure: arready held low 5 cycles -> araddr/arlen stable and arvalid held. rvalid gaps between beats -> fill_valid only on beat cycles; req_ready stays 0 until after done.
- Reset mid-refill: assert reset after beat 1 -> outputs clear asynchronously and req_ready=1. A new request after release refills from beat 0 with err=0.
